sequence_detector_shiftreg_param: RTL and testbench
===================================================

Name: sequence_detector_shiftreg_param

Overview:
- Parametrised, run-time programmable serial pattern detector; next generation of the fixed 6-bit 101001 shift-register detector.
- Adds generic pattern length, programmable pattern and don't-care mask, per-bit valid qualifier, selectable overlap/non-overlap mode, and a saturating match counter.
- Sits on a serial bit stream (one bit per valid clock) and flags pattern hits to downstream control or status logic.

Parameters:
- WIDTH, 6, pattern length in bits (>=2).
- DEFAULT_PATTERN, 6'b101001, pattern loaded at reset; WIDTH bits, MSB = oldest bit.
- CNT_WIDTH, 16, match counter width (>=2).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_resetn  in  1  synchronous, active-low reset.
- i_data  in  1  serial data bit.
- i_valid  in  1  i_data is sampled only when 1.
- i_cfg_load  in  1  latch i_pattern/i_mask and flush history.
- i_pattern  in  WIDTH  new pattern, MSB = oldest bit.
- i_mask  in  WIDTH  compare enable per bit; 1 = compare, 0 = don't care.
- i_overlap  in  1  1 = overlapping detection; 0 = non-overlapping.
- i_clear_cnt  in  1  synchronous clear of the match counter.
- o_pattern_found  out  1  one-cycle match pulse, registered.
- o_match_cnt  out  CNT_WIDTH  saturating count of matches.
- o_cnt_sat  out  1  sticky; set when the counter reaches all-ones.

Behaviour:
- Reset (i_resetn=0 at an edge):
  - sr = 0, fill = 0.
  - pattern = DEFAULT_PATTERN, mask = all ones.
  - o_pattern_found = 0, o_match_cnt = 0, o_cnt_sat = 0.
  - Reset overrides every other input.
- Shift: on an edge with i_valid=1 and i_cfg_load=0:
  - sr <= {sr[WIDTH-2:0], i_data}.
  - fill <= min(fill+1, WIDTH); fill counts bits accepted since the last flush.
- Match condition, evaluated on next-state values: i_valid=1 and fill_next==WIDTH and ((sr_next ^ pattern) & mask)==0.
- Latency: o_pattern_found goes high for exactly one cycle, in the cycle after the edge that sampled the pattern's last bit.
- In any cycle without a match, o_pattern_found = 0; i_valid=0 holds sr and fill.
- Overlap mode:
  - i_overlap=1: fill stays WIDTH after a match, so a suffix of the match can start the next match.
  - i_overlap=0: a match forces fill <= 0 (sr still shifts), so the next match needs WIDTH fresh valid bits.
  - i_overlap is sampled every edge.
- Config load (i_cfg_load=1):
  - pattern <= i_pattern, mask <= i_mask.
  - sr <= 0, fill <= 0, o_pattern_found <= 0.
  - i_data in that cycle is ignored; the counter is untouched.
- Mask all zeros: every valid bit matches once fill==WIDTH. This is legal and intended.
- Counter:
  - On a match, o_match_cnt increments unless already all-ones.
  - o_cnt_sat <= 1 when the count becomes all-ones; it is sticky.
  - i_clear_cnt=1 zeroes both o_match_cnt and o_cnt_sat. If it coincides with a match, clear wins and the result is 0.
- Reset mid-pattern discards all history; no match can span a reset.

Decomposition:
- Package seq_det_pkg holds:
  - the default pattern constant 6'b101001;
  - default WIDTH/CNT_WIDTH constants;
  - a function computing masked match (sr, pattern, mask).
- Sub-module seq_det_sat_counter (CNT_WIDTH parameter; ports i_clk, i_resetn, i_inc, i_clr, o_cnt, o_sat) contains the saturating counter and sticky flag.
- The shift register, fill counter and config registers stay in the top module.

Test Plan:
- Overlap, defaults, i_valid=1 continuously, stream 1,0,1,0,0,1,0,1,0,0,1 with i_overlap=1 -> two pulses, one cycle after bit 6 and after bit 11; o_match_cnt=2.
- Same stream with i_overlap=0 -> exactly one pulse, after bit 6; o_match_cnt=1.
- Valid gaps: stream 101001 with i_valid=0 for 3 cycles between bits 3 and 4 while i_data toggles -> one pulse, one cycle after the 6th valid bit; no pulse during the gaps.
- Reset mid-pattern: 1,0,1, then i_resetn=0 for one cycle, then 0,0,1 -> no pulse; pattern reverts to 101001. A full 101001 afterwards -> pulse.
- Mask and load:
  - Load i_pattern=101001, i_mask=110111 via i_cfg_load; stream 1,0,0,0,0,1 -> pulse.
  - Then load 111000 / 111111 mid-stream -> history flushed, no pulse until 1,1,1,0,0,0 is received.
- Saturation with CNT_WIDTH=2: 4 matches -> o_match_cnt=3, o_cnt_sat=1 after the 3rd match and held. i_clear_cnt together with the 5th match -> cnt=0, sat=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and the masked compare used by the serial pattern detector.
package seq_det_pkg;

    localparam int            SEQ_DEFAULT_WIDTH     = 6;
    localparam int            SEQ_DEFAULT_CNT_WIDTH = 16;
    localparam int            SEQ_MAX_WIDTH         = 64;
    localparam logic [5:0]    SEQ_DEFAULT_PATTERN   = 6'b101001;

    // Operands are zero-extended to SEQ_MAX_WIDTH, so unused upper bits never mismatch.
    function automatic logic seq_masked_match(
        input logic [SEQ_MAX_WIDTH-1:0] sr,
        input logic [SEQ_MAX_WIDTH-1:0] pattern,
        input logic [SEQ_MAX_WIDTH-1:0] mask
    );
        return ((sr ^ pattern) & mask) == '0;
    endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating match counter with a sticky flag that is set when the count reaches all-ones.
module seq_det_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    input  logic                 i_inc,
    input  logic                 i_clr,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic                 o_sat
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_sat;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (i_clr) begin
            // A clear that coincides with an increment wins.
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
            if (r_cnt == CNT_MAX - CNT_WIDTH'(1)) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = r_sat;

endmodule

// File: rtl/sequence_detector_shiftreg_param.sv
// Programmable serial pattern detector: shift register with fill tracking, masked compare,
// overlap control and a saturating hit counter.
module sequence_detector_shiftreg_param
    import seq_det_pkg::*;
#(
    parameter int               WIDTH           = SEQ_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] DEFAULT_PATTERN = WIDTH'(SEQ_DEFAULT_PATTERN),
    parameter int               CNT_WIDTH       = SEQ_DEFAULT_CNT_WIDTH
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    input  logic                 i_data,
    input  logic                 i_valid,
    input  logic                 i_cfg_load,
    input  logic [WIDTH-1:0]     i_pattern,
    input  logic [WIDTH-1:0]     i_mask,
    input  logic                 i_overlap,
    input  logic                 i_clear_cnt,
    output logic                 o_pattern_found,
    output logic [CNT_WIDTH-1:0] o_match_cnt,
    output logic                 o_cnt_sat
);

    localparam int               FILL_W    = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);

    logic [WIDTH-1:0]  r_sr;
    logic [FILL_W-1:0] r_fill;
    logic [WIDTH-1:0]  r_pattern;
    logic [WIDTH-1:0]  r_mask;
    logic              r_found;

    logic [WIDTH-1:0]  w_sr_next;
    logic [FILL_W-1:0] w_fill_next;
    logic              w_match;

    always_comb begin
        w_sr_next   = r_sr;
        w_fill_next = r_fill;
        if (i_valid) begin
            w_sr_next   = {r_sr[WIDTH-2:0], i_data};
            w_fill_next = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);
        end
    end

    // Compare against the history as it will be after this edge.
    assign w_match = i_valid && !i_cfg_load && (w_fill_next == FILL_FULL) &&
                     seq_masked_match(SEQ_MAX_WIDTH'(w_sr_next),
                                      SEQ_MAX_WIDTH'(r_pattern),
                                      SEQ_MAX_WIDTH'(r_mask));

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_sr      <= '0;
            r_fill    <= '0;
            r_pattern <= DEFAULT_PATTERN;
            r_mask    <= '1;
            r_found   <= 1'b0;
        end else if (i_cfg_load) begin
            r_sr      <= '0;
            r_fill    <= '0;
            r_pattern <= i_pattern;
            r_mask    <= i_mask;
            r_found   <= 1'b0;
        end else begin
            r_sr    <= w_sr_next;
            r_fill  <= (w_match && !i_overlap) ? '0 : w_fill_next;
            r_found <= w_match;
        end
    end

    seq_det_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_sat_counter (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .i_inc    (w_match),
        .i_clr    (i_clear_cnt),
        .o_cnt    (o_match_cnt),
        .o_sat    (o_cnt_sat)
    );

    assign o_pattern_found = r_found;

endmodule

// File: tb/tb_sequence_detector_shiftreg_param.sv
// Directed bench: default-width detector (16-bit counter) alongside a 2-bit-counter copy.
module tb_sequence_detector_shiftreg_param;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_data;
    logic        i_valid;
    logic        i_cfg_load;
    logic [5:0]  i_pattern;
    logic [5:0]  i_mask;
    logic        i_overlap;
    logic        i_clear_cnt;

    logic        found_a;
    logic [15:0] cnt_a;
    logic        sat_a;
    logic        found_b;
    logic [1:0]  cnt_b;
    logic        sat_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sequence_detector_shiftreg_param dut_a (
        .i_clk           (clk),
        .i_resetn        (resetn),
        .i_data          (i_data),
        .i_valid         (i_valid),
        .i_cfg_load      (i_cfg_load),
        .i_pattern       (i_pattern),
        .i_mask          (i_mask),
        .i_overlap       (i_overlap),
        .i_clear_cnt     (i_clear_cnt),
        .o_pattern_found (found_a),
        .o_match_cnt     (cnt_a),
        .o_cnt_sat       (sat_a)
    );

    sequence_detector_shiftreg_param #(.CNT_WIDTH(2)) dut_b (
        .i_clk           (clk),
        .i_resetn        (resetn),
        .i_data          (i_data),
        .i_valid         (i_valid),
        .i_cfg_load      (i_cfg_load),
        .i_pattern       (i_pattern),
        .i_mask          (i_mask),
        .i_overlap       (i_overlap),
        .i_clear_cnt     (i_clear_cnt),
        .o_pattern_found (found_b),
        .o_match_cnt     (cnt_b),
        .o_cnt_sat       (sat_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic d, input logic v, input logic exp_found, input string tag);
        @(negedge clk);
        i_data  = d;
        i_valid = v;
        @(posedge clk);
        #1;
        chk({tag, " found_a"}, 32'(found_a), 32'(exp_found));
        chk({tag, " found_b"}, 32'(found_b), 32'(exp_found));
    endtask

    task automatic send_stream(input logic [31:0] bits, input int n,
                               input logic [31:0] exp, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i], 1'b1, exp[i], $sformatf("%s bit%0d", tag, n - i));
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        resetn      = 1'b0;
        i_valid     = 1'b0;
        i_cfg_load  = 1'b0;
        i_clear_cnt = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, " rst found"}, 32'(found_a), 32'd0);
        chk({tag, " rst cnt"},   32'(cnt_a),   32'd0);
        chk({tag, " rst sat"},   32'(sat_a),   32'd0);
        resetn = 1'b1;
    endtask

    task automatic load_cfg(input logic [5:0] pat, input logic [5:0] msk, input string tag);
        @(negedge clk);
        i_cfg_load = 1'b1;
        i_pattern  = pat;
        i_mask     = msk;
        i_valid    = 1'b1;
        i_data     = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " load found"}, 32'(found_a), 32'd0);
        i_cfg_load = 1'b0;
        i_valid    = 1'b0;
    endtask

    initial begin
        resetn      = 1'b0;
        i_data      = 1'b0;
        i_valid     = 1'b0;
        i_cfg_load  = 1'b0;
        i_pattern   = 6'b0;
        i_mask      = 6'b0;
        i_overlap   = 1'b1;
        i_clear_cnt = 1'b0;

        // Overlapping: 101001 shares its last '1' with the next occurrence.
        do_reset("t1");
        i_overlap = 1'b1;
        send_stream(32'b10100101001, 11, 32'b00000100001, "t1");
        chk("t1 cnt", 32'(cnt_a), 32'd2);

        // Non-overlapping: only 5 fresh bits after the first hit.
        do_reset("t2");
        i_overlap = 1'b0;
        send_stream(32'b10100101001, 11, 32'b00000100000, "t2");
        chk("t2 cnt", 32'(cnt_a), 32'd1);

        // Valid gaps while i_data toggles.
        do_reset("t3");
        i_overlap = 1'b1;
        send_stream(32'b101, 3, 32'b000, "t3a");
        send(1'b1, 1'b0, 1'b0, "t3 gap1");
        send(1'b0, 1'b0, 1'b0, "t3 gap2");
        send(1'b1, 1'b0, 1'b0, "t3 gap3");
        send_stream(32'b001, 3, 32'b001, "t3b");
        chk("t3 cnt", 32'(cnt_a), 32'd1);

        // Reset mid-pattern flushes history and restores the default pattern.
        do_reset("t4");
        load_cfg(6'b111000, 6'b111111, "t4");
        send_stream(32'b101, 3, 32'b000, "t4a");
        @(negedge clk);
        resetn  = 1'b0;
        i_valid = 1'b1;
        i_data  = 1'b0;
        @(posedge clk);
        #1;
        chk("t4 midrst found", 32'(found_a), 32'd0);
        chk("t4 midrst cnt",   32'(cnt_a),   32'd0);
        resetn = 1'b1;
        send_stream(32'b001, 3, 32'b000, "t4b");
        send_stream(32'b101001, 6, 32'b000001, "t4c");
        chk("t4 cnt", 32'(cnt_a), 32'd1);

        // Don't-care bit, then a reload mid-stream that must flush history.
        do_reset("t5");
        i_overlap = 1'b1;
        load_cfg(6'b101001, 6'b110111, "t5a");
        send_stream(32'b100001, 6, 32'b000001, "t5a");
        send_stream(32'b11100, 5, 32'b00000, "t5b");
        load_cfg(6'b111000, 6'b111111, "t5c");
        send(1'b0, 1'b1, 1'b0, "t5 post-load");
        send_stream(32'b111000, 6, 32'b000001, "t5d");
        chk("t5 cnt", 32'(cnt_a), 32'd2);

        // Saturation on the 2-bit counter; clear coinciding with the 5th hit.
        do_reset("t6");
        i_overlap = 1'b1;
        begin
            logic [25:0] bits;
            logic [25:0] hits;
            int          k;
            bits = 26'b10100101001010010100101001;
            hits = 26'b00000100001000010000100001;
            k    = 0;
            for (int i = 25; i >= 1; i--) begin
                send(bits[i], 1'b1, hits[i], $sformatf("t6 bit%0d", 26 - i));
                if (hits[i]) begin
                    k++;
                    chk($sformatf("t6 cnt m%0d", k), 32'(cnt_b), (k >= 3) ? 32'd3 : 32'(k));
                    chk($sformatf("t6 sat m%0d", k), 32'(sat_b), (k >= 3) ? 32'd1 : 32'd0);
                    chk($sformatf("t6 wide cnt m%0d", k), 32'(cnt_a), 32'(k));
                end
            end
            i_clear_cnt = 1'b1;
            send(bits[0], 1'b1, hits[0], "t6 bit26");
            i_clear_cnt = 1'b0;
            chk("t6 clr cnt", 32'(cnt_b), 32'd0);
            chk("t6 clr sat", 32'(sat_b), 32'd0);
            chk("t6 clr wide cnt", 32'(cnt_a), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
